// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the SHA-256 compression datapath: INIT, 64 rounds, FINAL digest add.
// Optional build macro SHA_STEP_MODE_EN enables single-stepping rounds from the step_n button.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS    = 64,
  parameter int unsigned MSG_WORDS = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       first_block,
  input  logic       abort,
  input  logic       step_n,
  output logic       init_en,
  output logic       iv_sel,
  output logic       round_en,
  output logic [5:0] round,
  output logic [5:0] k_addr,
  output logic       w_sel,
  output logic       final_add,
  output logic       busy,
  output logic       finished,
  output logic [6:0] count_decrement
);

  localparam int unsigned RW = 6;
  localparam int unsigned CW = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            step_pulse;

  logic            init_en_d, iv_sel_d, round_en_d, w_sel_d;
  logic            final_add_d, busy_d, finished_d;
  logic [RW-1:0]   round_d;
  logic [CW-1:0]   count_d;

`ifdef SHA_STEP_MODE_EN
  // Two-flop synchroniser plus history flop; a round advances on each high->low of step_n.
  logic [2:0] step_sync_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) step_sync_q <= 3'b111;
    else        step_sync_q <= {step_sync_q[1:0], step_n};
  end

  assign step_pulse = step_sync_q[2] & ~step_sync_q[1];
`else
  logic unused_step_n;
  assign unused_step_n = step_n;
  assign step_pulse    = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_ROUND;
      S_ROUND: if (round_en && (round == RW'(ROUNDS - 1))) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    init_en_d   = 1'b0;
    iv_sel_d    = iv_sel;
    round_en_d  = 1'b0;
    round_d     = '0;
    w_sel_d     = 1'b0;
    final_add_d = 1'b0;
    busy_d      = 1'b0;
    finished_d  = 1'b0;
    count_d     = '0;
    case (state_d)
      S_IDLE: iv_sel_d = 1'b0;
      S_INIT: begin
        init_en_d = 1'b1;
        busy_d    = 1'b1;
        iv_sel_d  = first_block;
        count_d   = CW'(ROUNDS);
      end
      S_ROUND: begin
        busy_d     = 1'b1;
        // round is 0 coming out of INIT, so this also covers entry
        round_d    = round + RW'(round_en);
        round_en_d = step_pulse;
        w_sel_d    = (round_d >= RW'(MSG_WORDS));
        count_d    = CW'(ROUNDS) - CW'(round_d);
      end
      S_FINAL: begin
        final_add_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE:  finished_d = 1'b1;
      default: iv_sel_d = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      init_en         <= 1'b0;
      iv_sel          <= 1'b0;
      round_en        <= 1'b0;
      round           <= '0;
      w_sel           <= 1'b0;
      final_add       <= 1'b0;
      busy            <= 1'b0;
      finished        <= 1'b0;
      count_decrement <= '0;
    end else begin
      init_en         <= init_en_d;
      iv_sel          <= iv_sel_d;
      round_en        <= round_en_d;
      round           <= round_d;
      w_sel           <= w_sel_d;
      final_add       <= final_add_d;
      busy            <= busy_d;
      finished        <= finished_d;
      count_decrement <= count_d;
    end
  end

  // K-ROM address tracks the round register directly
  assign k_addr = round;

endmodule
